// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of hazard/stall sources and the per-stage
// enable/flush outputs of the pipeline sequencing controller.
//   master : pipeline side; drives hazard inputs and observes enables/flushes
//   slave  : hazard_ctrl; observes hazard inputs and drives enables/flushes
// Parameter CNT_WIDTH must match the controller's stall-counter width.
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 hc_i_load_use;
  logic                 hc_i_branch_taken;
  logic                 hc_i_jump;
  logic                 hc_i_md_start;
  logic                 hc_i_md_done;
  logic                 hc_i_imem_ready;
  logic                 hc_i_dmem_ready;
  logic                 hc_o_pc_en;
  logic                 hc_o_fd_en;
  logic                 hc_o_de_en;
  logic                 hc_o_em_en;
  logic                 hc_o_mw_en;
  logic                 hc_o_fd_flush;
  logic                 hc_o_de_flush;
  logic                 hc_o_em_flush;
  logic                 hc_o_md_busy;
  logic [CNT_WIDTH-1:0] hc_o_stall_cnt;

  modport master (
    output hc_i_load_use, hc_i_branch_taken, hc_i_jump, hc_i_md_start,
           hc_i_md_done, hc_i_imem_ready, hc_i_dmem_ready,
    input  hc_o_pc_en, hc_o_fd_en, hc_o_de_en, hc_o_em_en, hc_o_mw_en,
           hc_o_fd_flush, hc_o_de_flush, hc_o_em_flush, hc_o_md_busy,
           hc_o_stall_cnt
  );

  modport slave (
    input  hc_i_load_use, hc_i_branch_taken, hc_i_jump, hc_i_md_start,
           hc_i_md_done, hc_i_imem_ready, hc_i_dmem_ready,
    output hc_o_pc_en, hc_o_fd_en, hc_o_de_en, hc_o_em_en, hc_o_mw_en,
           hc_o_fd_flush, hc_o_de_flush, hc_o_em_flush, hc_o_md_busy,
           hc_o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Merges load-use, branch, jump, mul/div and memory-wait events into PC and
// pipeline-register enables/flushes, and counts PC-stall cycles (saturating).
// Ports:
//   i_clk  : core clock, rising edge
//   i_rst  : asynchronous active-low reset
//   hc     : hazard_ctrl_if.slave (hazard inputs, enables/flushes, busy, count)
// Enables/flushes are combinational from state and inputs; state, mul/div
// countdown and stall counter are registered.
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave hc
);

  localparam int CD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_LOAD_BUBBLE = 2'd1,
    ST_MD_WAIT     = 2'd2,
    ST_MEM_WAIT    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CD_W-1:0]      r_md_cnt;
  logic [CD_W-1:0]      w_md_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
  logic w_fd_flush, w_de_flush, w_em_flush, w_md_busy;

  // Next-state, countdown and per-stage enable/flush decode.
  always_comb begin
    w_pc_en      = 1'b1;
    w_fd_en      = 1'b1;
    w_de_en      = 1'b1;
    w_em_en      = 1'b1;
    w_mw_en      = 1'b1;
    w_fd_flush   = 1'b0;
    w_de_flush   = 1'b0;
    w_em_flush   = 1'b0;
    w_md_busy    = 1'b0;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    if (!i_rst) begin
      w_pc_en      = 1'b0;
      w_fd_en      = 1'b0;
      w_de_en      = 1'b0;
      w_em_en      = 1'b0;
      w_mw_en      = 1'b0;
      w_fd_flush   = 1'b1;
      w_de_flush   = 1'b1;
      w_em_flush   = 1'b1;
      w_state_nxt  = ST_RUN;
      w_md_cnt_nxt = {CD_W{1'b0}};
    end else begin
      case (r_state)
        ST_RUN, ST_LOAD_BUBBLE: begin
          // A bubble lasts one cycle; later events may redirect below.
          w_state_nxt = ST_RUN;
          if (!hc.hc_i_dmem_ready) begin
            w_pc_en     = 1'b0;
            w_fd_en     = 1'b0;
            w_de_en     = 1'b0;
            w_em_en     = 1'b0;
            w_mw_en     = 1'b0;
            w_state_nxt = ST_MEM_WAIT;
          end else if (hc.hc_i_md_start) begin
            // Older instructions keep draining through MEM/WB.
            w_pc_en      = 1'b0;
            w_fd_en      = 1'b0;
            w_de_en      = 1'b0;
            w_em_flush   = 1'b1;
            w_md_cnt_nxt = CD_W'(MD_LATENCY - 1);
            w_state_nxt  = ST_MD_WAIT;
          end else begin
            if (hc.hc_i_branch_taken) begin
              // load_use/jump belong to wrong-path instructions here.
              w_fd_flush = 1'b1;
              w_de_flush = 1'b1;
            end else if (hc.hc_i_load_use && (r_state == ST_RUN)) begin
              // In the bubble cycle the load has already left EX.
              w_pc_en     = 1'b0;
              w_fd_en     = 1'b0;
              w_de_flush  = 1'b1;
              w_state_nxt = ST_LOAD_BUBBLE;
            end else if (hc.hc_i_jump) begin
              w_fd_flush = 1'b1;
            end else begin
              w_fd_flush = 1'b0;
            end
            // Fetch miss: hold PC and bubble IF/ID unless IF/ID is held.
            if (!hc.hc_i_imem_ready) begin
              w_pc_en = 1'b0;
              if (w_fd_en) begin
                w_fd_flush = 1'b1;
              end else begin
                w_fd_flush = 1'b0;
              end
            end else begin
              w_pc_en = w_pc_en;
            end
          end
        end
        ST_MD_WAIT: begin
          w_md_busy  = 1'b1;
          w_pc_en    = 1'b0;
          w_fd_en    = 1'b0;
          w_de_en    = 1'b0;
          w_em_flush = 1'b1;
          if (!hc.hc_i_dmem_ready) begin
            // MEM is stuck: freeze EX/MEM and MEM/WB, keep counting down.
            w_mw_en = 1'b0;
            w_em_en = 1'b0;
            if (r_md_cnt != {CD_W{1'b0}}) begin
              w_md_cnt_nxt = r_md_cnt - CD_W'(1);
            end else begin
              w_md_cnt_nxt = r_md_cnt;
            end
          end else if ((r_md_cnt == {CD_W{1'b0}}) || hc.hc_i_md_done) begin
            // Exit cycle: result is captured into EX/MEM, pipeline resumes.
            w_pc_en      = 1'b1;
            w_fd_en      = 1'b1;
            w_de_en      = 1'b1;
            w_em_flush   = 1'b0;
            w_md_cnt_nxt = {CD_W{1'b0}};
            w_state_nxt  = ST_RUN;
          end else begin
            w_md_cnt_nxt = r_md_cnt - CD_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (hc.hc_i_dmem_ready) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_en = 1'b0;
            w_fd_en = 1'b0;
            w_de_en = 1'b0;
            w_em_en = 1'b0;
            w_mw_en = 1'b0;
          end
        end
        default: begin
          w_state_nxt  = ST_RUN;
          w_md_cnt_nxt = {CD_W{1'b0}};
        end
      endcase
    end
  end

  // State, mul/div countdown and saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= {CD_W{1'b0}};
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!w_pc_en && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign hc.hc_o_pc_en     = w_pc_en;
  assign hc.hc_o_fd_en     = w_fd_en;
  assign hc.hc_o_de_en     = w_de_en;
  assign hc.hc_o_em_en     = w_em_en;
  assign hc.hc_o_mw_en     = w_mw_en;
  assign hc.hc_o_fd_flush  = w_fd_flush;
  assign hc.hc_o_de_flush  = w_de_flush;
  assign hc.hc_o_em_flush  = w_em_flush;
  assign hc.hc_o_md_busy   = w_md_busy;
  assign hc.hc_o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Combines hazard and stall sources into per-stage register enables and flushes:
  - load-use stall from the forwarding unit
  - EX-stage branch resolution
  - ID-stage jump
  - multi-cycle multiply/divide in EX
  - instruction- and data-memory wait
- Sits beside the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MD_LATENCY, 8: fixed mul/div latency in cycles (>=2). Used when hc_i_md_done never arrives earlier.
- CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- hc_i_load_use  input  1  ID instruction depends on a load currently in EX.
- hc_i_branch_taken  input  1  branch in EX resolved taken.
- hc_i_jump  input  1  jump decoded in ID.
- hc_i_md_start  input  1  mul/div instruction entering execution in EX.
- hc_i_md_done  input  1  mul/div unit result ready (early completion).
- hc_i_imem_ready  input  1  instruction fetch data valid this cycle.
- hc_i_dmem_ready  input  1  data memory access in MEM completes this cycle.
- hc_o_pc_en  output  1  PC update enable.
- hc_o_fd_en, hc_o_de_en, hc_o_em_en, hc_o_mw_en  output  1 each  pipeline register enables.
- hc_o_fd_flush, hc_o_de_flush, hc_o_em_flush  output  1 each  load a bubble (NOP, regwrite=0) into that register.
- hc_o_md_busy  output  1  high while in MD_WAIT.
- hc_o_stall_cnt  output  CNT_WIDTH  cycles with hc_o_pc_en=0 since reset, saturating.

Behaviour:
- States: RUN, LOAD_BUBBLE, MD_WAIT, MEM_WAIT.
- State register and counters are reset asynchronously; outputs are combinational from state and inputs.

Reset (i_rst=0, immediately and asynchronously):
- State goes to RUN.
- All enables are 0 and all flushes are 1.
- hc_o_md_busy=0, hc_o_stall_cnt=0, MD countdown=0.
- Reset asserted mid-MD_WAIT or mid-MEM_WAIT aborts the operation; there is no residual state.

RUN, default: all enables 1, all flushes 0. Event priority, highest first:
1. hc_i_dmem_ready=0 while MEM holds a memory op:
   - All enables 0, no flushes.
   - Go to MEM_WAIT.
2. hc_i_md_start=1:
   - pc_en=fd_en=de_en=0, em_flush=1, mw_en=1 (older instructions drain).
   - Load countdown with MD_LATENCY-1; go to MD_WAIT.
3. hc_i_branch_taken=1:
   - pc_en=1 (PC takes the target), fd_flush=1, de_flush=1.
   - hc_i_load_use and hc_i_jump are ignored (they refer to wrong-path instructions).
4. hc_i_load_use=1:
   - pc_en=0, fd_en=0, de_flush=1.
   - Go to LOAD_BUBBLE.
5. hc_i_jump=1: fd_flush=1.
6. Independently of items 3–5, hc_i_imem_ready=0 forces pc_en=0 and fd_flush=1, unless fd_en=0 (fd hold takes precedence over fd flush).
- hc_i_md_start and hc_i_branch_taken are both EX-stage signals and mutually exclusive. If both are high, md_start wins and the bench flags an assertion.

LOAD_BUBBLE (exactly 1 cycle):
- hc_i_load_use is ignored (the load has moved to MEM).
- Outputs follow the RUN rules for the remaining events (dmem, md_start, branch, jump, imem) with the same priority.
- Next state: RUN, or MEM_WAIT / MD_WAIT if those events fire.

MD_WAIT:
- Outputs: hc_o_md_busy=1, pc_en=fd_en=de_en=0, em_flush=1, mw_en=1.
- Each cycle the countdown decrements.
- Exit when countdown==0 or hc_i_md_done=1. In the exit cycle, outputs are RUN defaults and de_en=1 (the result is captured into EX/MEM); next state is RUN.
- Total stall = MD_LATENCY cycles, or fewer with early done.
- Branch, jump and load_use inputs are ignored in MD_WAIT.
- hc_i_dmem_ready=0 in MD_WAIT: mw_en=0 and em_en=0, countdown keeps running. If the countdown expires first, hold in MD_WAIT with countdown=0 until dmem_ready=1.

MEM_WAIT:
- All enables 0, no flushes.
- When hc_i_dmem_ready=1: that cycle outputs RUN defaults (no other events evaluated); next state RUN.

Stall counter:
- Increments on each clock where hc_o_pc_en=0 and i_rst=1.
- Saturates at 2^CNT_WIDTH-1 and never wraps.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with random inputs -> all enables 0, flushes 1, stall_cnt=0; first cycle after release with quiet inputs -> all enables 1, flushes 0.
- Load-use: pulse hc_i_load_use for 2 cycles -> cycle 1: pc_en=0, fd_en=0, de_flush=1; cycle 2 (LOAD_BUBBLE): all enables 1; stall_cnt=1.
- Branch vs load-use same cycle: hc_i_branch_taken=1, hc_i_load_use=1 -> pc_en=1, fd_flush=1, de_flush=1; state stays RUN.
- Mul/div, MD_LATENCY=8: md_start pulse, no done -> md_busy high 8 cycles, pc_en=0 for 8 cycles, de_en=1 on cycle 8; repeat with done on cycle 3 -> busy 3 cycles.
- Memory wait: dmem_ready=0 for 4 cycles during a load -> all enables 0 for 4 cycles, resume on the 5th; stall_cnt +4. Apply reset during cycle 2 -> RUN immediately, counter 0.
- Saturation with CNT_WIDTH=4: 20 imem-not-ready cycles -> stall_cnt=15, fd_flush=1 each cycle.
